// File: rtl/base_ram_ctrl.sv
// Single-port SRAM controller: one outstanding read or byte-masked write,
// all SRAM pins registered, fixed read/write strobe timing.
module base_ram_ctrl #(
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic        clk_50M,
    input  logic        reset_btn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [19:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    localparam logic [2:0] RD_CNT = 3'(RD_WAIT);
    localparam logic [2:0] WR_CNT = 3'(WR_WAIT - 1);

    state_t      state;
    state_t      state_n;
    logic [2:0]  cnt;
    logic [2:0]  cnt_n;
    logic        accept;
    logic        done_rd;
    logic        done_wr;
    logic        wr_n;
    logic        drive;
    logic [31:0] data_o;

    assign req_ready     = (state == IDLE);
    assign base_ram_data = drive ? data_o : 32'bz;

    always_ff @(posedge clk_50M or posedge reset_btn) begin
        if (reset_btn) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        done_rd = 1'b0;
        done_wr = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (!req_we) begin
                        state_n = RD;
                        cnt_n   = RD_CNT;
                    end else if (req_be != 4'h0) begin
                        state_n = WR_SETUP;
                    end else begin
                        // empty byte mask: nothing to strobe, answer at once
                        done_wr = 1'b1;
                    end
                end
            end
            RD: begin
                if (cnt == 3'd0) begin
                    state_n = IDLE;
                    done_rd = 1'b1;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            WR_SETUP: begin
                state_n = WR_PULSE;
                cnt_n   = WR_CNT;
            end
            WR_PULSE: begin
                if (cnt == 3'd0) begin
                    state_n = WR_HOLD;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            WR_HOLD: begin
                state_n = IDLE;
                done_wr = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign wr_n = (state_n == WR_SETUP) || (state_n == WR_PULSE) ||
                  (state_n == WR_HOLD);

    // pins are loaded from the next state so they change with the state itself
    always_ff @(posedge clk_50M or posedge reset_btn) begin
        if (reset_btn) begin
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'h0;
            base_ram_addr <= 20'h0;
            base_ram_be_n <= 4'hF;
            base_ram_ce_n <= 1'b1;
            base_ram_oe_n <= 1'b1;
            base_ram_we_n <= 1'b1;
            drive         <= 1'b0;
            data_o        <= 32'h0;
        end else begin
            resp_valid    <= done_rd | done_wr;
            if (done_rd) begin
                resp_rdata <= base_ram_data;
            end
            if (accept) begin
                base_ram_addr <= req_addr;
            end
            if (accept && req_we) begin
                data_o <= req_wdata;
            end
            base_ram_ce_n <= (state_n == IDLE);
            base_ram_oe_n <= (state_n != RD);
            base_ram_we_n <= (state_n != WR_PULSE);
            drive         <= wr_n;
            unique case (1'b1)
                (state_n == RD):       base_ram_be_n <= 4'h0;
                (state_n == WR_SETUP): base_ram_be_n <= ~req_be;
                (state_n == IDLE):     base_ram_be_n <= 4'hF;
                default:               base_ram_be_n <= base_ram_be_n;
            endcase
        end
    end

endmodule

// File: doc/base_ram_ctrl.md
BASE_RAM_CTRL -- requirements
Module: base_ram_ctrl

Interface
REQ-001 The module SHALL have parameter RD_WAIT, default 1, giving the number of extra read-strobe cycles (legal range 0..7).
REQ-002 The module SHALL have parameter WR_WAIT, default 1, giving the number of cycles base_ram_we_n is held low (legal range 1..7).
REQ-003 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk_50M  in  1  sole clock, rising edge.
REQ-005 reset_btn  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_be  in  4  byte enables, active-high, bit i = data[8i+7:8i].
REQ-010 req_addr  in  20  SRAM word address.
REQ-011 req_wdata  in  32  write data.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rdata  out  32  read data, valid while resp_valid is high for a read.
REQ-014 base_ram_data  inout  32  SRAM data bus.
REQ-015 base_ram_addr  out  20  SRAM address.
REQ-016 base_ram_be_n  out  4  SRAM byte enables, active-low.
REQ-017 base_ram_ce_n, base_ram_oe_n, base_ram_we_n  out  1 each  SRAM strobes, active-low.

Function
REQ-018 States SHALL be IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, driven by a 3-bit wait counter.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; addr, be, wdata and we SHALL be latched at that edge.
REQ-021 req_valid while req_ready=0 SHALL be ignored and not queued; the requester holds the request.
REQ-022 Every SRAM output SHALL come directly from a flop, with no combinational path from the req_* inputs.
REQ-023 In IDLE the outputs SHALL be: ce_n=1, oe_n=1, we_n=1, be_n=4'hF, data bus high-Z, and base_ram_addr holding its last value.
REQ-024 Read, entry: IDLE -> RD on acceptance.
REQ-025 Read, RD state: ce_n=0, oe_n=0, we_n=1, be_n=4'h0 (always a full word), addr = latched address, bus high-Z.
REQ-026 Read, exit: RD lasts 1+RD_WAIT cycles; base_ram_data SHALL be sampled into resp_rdata on the last RD edge, and the state returns to IDLE.
REQ-027 Read, response: resp_valid=1 in the first IDLE cycle after RD, so the read response is at edge 2+RD_WAIT after acceptance (3 with the default).
REQ-028 Write, sequence: IDLE -> WR_SETUP (1 cycle) -> WR_PULSE (WR_WAIT cycles) -> WR_HOLD (1 cycle) -> IDLE.
REQ-029 Write, all three write states: ce_n=0, oe_n=1, be_n=~latched be, bus driven with latched wdata, addr = latched address.
REQ-030 Write, strobe: we_n=0 only in WR_PULSE.
REQ-031 Write, response: resp_valid=1 in the first IDLE cycle after WR_HOLD, and resp_rdata SHALL be unchanged.
REQ-032 A write with req_be=4'h0 SHALL produce no SRAM strobes (ce_n and we_n stay 1) and SHALL give resp_valid=1 in the cycle after acceptance.
REQ-033 Back-to-back requests: a request accepted in the same cycle as resp_valid SHALL start immediately, giving zero idle gap.
REQ-034 Bus turnaround: the data bus SHALL be high-Z for at least one cycle between a WR_HOLD and a following RD.
REQ-035 resp_rdata SHALL hold its value until the next read completes.
REQ-036 resp_valid SHALL never be high for two consecutive cycles for the same request.

Reset
REQ-037 Asserting reset_btn SHALL immediately and asynchronously force the state to IDLE and set ce_n=1, oe_n=1, we_n=1, be_n=4'hF, bus high-Z, base_ram_addr=20'h0, resp_valid=0, resp_rdata=32'h0 and the wait counter to 0.
REQ-038 A transaction cut by reset SHALL produce no resp_valid, and the first request after reset release SHALL be handled normally.

Verification
REQ-039 SRAM preloaded with word 5 = 32'h8C1F0004; read addr 20'h00005 -> resp_valid high at edge 3 after acceptance, resp_rdata=32'h8C1F0004, we_n stays 1 throughout.
REQ-040 Write addr 20'h00010, wdata 32'hDEADBEEF, be 4'b0101, then read the same address over old data 32'h11223344 -> resp_rdata=32'h11AD33EF, and we_n is low for exactly WR_WAIT=1 cycle.
REQ-041 Write with be=4'h0 -> resp_valid in the next cycle, ce_n never low, SRAM contents unchanged.
REQ-042 Continuous req_valid for read, write, read (RD_WAIT=0, WR_WAIT=2) -> exactly three resp_valid pulses, no gap between a response and the next acceptance, and the bus never driven while oe_n=0.
REQ-043 Assert reset_btn during WR_PULSE -> we_n=1 and bus high-Z within the same cycle, no resp_valid; after release a read of 20'h00001 completes normally.
